// File: rtl/restoring_divider_seq_if.sv
// restoring_divider_seq_if: start/busy/done handshake and operand/result bus of the sequential divider
//   master: drives start, signed_mode, dividend, divisor; observes results and status
//   slave : observes requests; drives quotient, remainder, busy, done, div_by_zero, overflow
interface restoring_divider_seq_if #(parameter int WIDTH = 8);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic             overflow;
   modport master (output start, signed_mode, dividend, divisor,
                   input  quotient, remainder, busy, done, div_by_zero, overflow);
   modport slave  (input  start, signed_mode, dividend, divisor,
                   output quotient, remainder, busy, done, div_by_zero, overflow);
endinterface

// File: rtl/restoring_divider_seq.sv
// restoring_divider_seq: sequential restoring divider, one quotient bit per clock, signed/unsigned
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of restoring_divider_seq_if (start/operands in, results/busy/done/flags out)
module restoring_divider_seq #(
   parameter int WIDTH = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   restoring_divider_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, ITER, FIX, ZERO} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic [CW-1:0]    r_cnt;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_ovf;
   logic             w_sa;
   logic             w_sb;
   logic             w_zero;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [WIDTH:0]   w_ash;
   logic [WIDTH:0]   w_d;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;
   assign w_sa    = bus.signed_mode & bus.dividend[WIDTH-1];
   assign w_sb    = bus.signed_mode & bus.divisor[WIDTH-1];
   assign w_zero  = bus.divisor == '0;
   assign w_mag_a = w_sa ? -bus.dividend : bus.dividend;
   assign w_mag_b = w_sb ? -bus.divisor : bus.divisor;
   // A stays below M after every step, so its shifted value fits in WIDTH+1 bits
   assign w_ash   = {r_a, r_q[WIDTH-1]};
   assign w_d     = w_ash - {1'b0, r_m};
   assign w_quo   = r_neg_q ? -r_q : r_q;
   assign w_rem   = r_neg_r ? -r_a : r_a;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_a             <= '0;
         r_q             <= '0;
         r_m             <= '0;
         r_cnt           <= '0;
         r_neg_q         <= 1'b0;
         r_neg_r         <= 1'b0;
         r_ovf           <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
         bus.overflow    <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (r_state)
            IDLE: if (bus.start) begin
               r_neg_q  <= w_sa ^ w_sb;
               r_neg_r  <= w_sa;
               r_ovf    <= bus.signed_mode & (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.divisor);
               r_a      <= '0;
               // on divide-by-zero Q carries the raw dividend through to the remainder
               r_q      <= w_zero ? bus.dividend : w_mag_a;
               r_m      <= w_mag_b;
               r_cnt    <= CW'(WIDTH-1);
               bus.busy <= 1'b1;
               r_state  <= w_zero ? ZERO : ITER;
            end
            ITER: begin
               r_a     <= w_d[WIDTH] ? w_ash[WIDTH-1:0] : w_d[WIDTH-1:0];
               r_q     <= {r_q[WIDTH-2:0], ~w_d[WIDTH]};
               r_cnt   <= r_cnt - 1'b1;
               r_state <= (r_cnt == '0) ? FIX : ITER;
            end
            FIX: begin
               bus.quotient    <= w_quo;
               bus.remainder   <= w_rem;
               bus.overflow    <= r_ovf;
               bus.div_by_zero <= 1'b0;
               bus.done        <= 1'b1;
               bus.busy        <= 1'b0;
               r_state         <= IDLE;
            end
            ZERO: begin
               bus.quotient    <= '1;
               bus.remainder   <= r_q;
               bus.div_by_zero <= 1'b1;
               bus.overflow    <= 1'b0;
               bus.done        <= 1'b1;
               bus.busy        <= 1'b0;
               r_state         <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_restoring_divider_seq.sv
// tb_restoring_divider_seq: directed self-checking bench for the 8- and 16-bit divider
//   drives both DUTs through their interfaces and checks results, flags, latency and handshake
module tb_restoring_divider_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   lat;
   int   n_done;
   restoring_divider_seq_if #(.WIDTH(8))  b8 ();
   restoring_divider_seq_if #(.WIDTH(16)) b16 ();
   restoring_divider_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
   restoring_divider_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b, output int l);
      b8.signed_mode = sm;
      b8.dividend    = a;
      b8.divisor     = b;
      b8.start       = 1'b1;
      @(posedge clk);
      l = 1;
      #1 b8.start = 1'b0;
      while (!b8.done && l < 50) begin
         @(posedge clk);
         l++;
         #1;
      end
   endtask
   task automatic op16(input logic [15:0] a, input logic [15:0] b, output int l);
      b16.signed_mode = 1'b0;
      b16.dividend    = a;
      b16.divisor     = b;
      b16.start       = 1'b1;
      @(posedge clk);
      l = 1;
      #1 b16.start = 1'b0;
      while (!b16.done && l < 50) begin
         @(posedge clk);
         l++;
         #1;
      end
   endtask
   task automatic res8(input string tag, input logic [7:0] q, input logic [7:0] r, input logic dz, input logic ov);
      chk({tag, " q"}, b8.quotient, q);
      chk({tag, " r"}, b8.remainder, r);
      chk({tag, " dz"}, b8.div_by_zero, dz);
      chk({tag, " ov"}, b8.overflow, ov);
      chk({tag, " busy"}, b8.busy, 1'b0);
   endtask
   initial begin
      b8.start = 1'b0;  b8.signed_mode = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
      b16.start = 1'b0; b16.signed_mode = 1'b0; b16.dividend = '0; b16.divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst q", b8.quotient, 0);
      chk("rst r", b8.remainder, 0);
      chk("rst flags", {b8.busy, b8.done, b8.div_by_zero, b8.overflow}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      op8(1'b0, 8'd55, 8'd0, lat);
      chk("dz lat", lat, 2);
      res8("dz", 8'hFF, 8'd55, 1'b1, 1'b0);
      @(posedge clk);
      #1 chk("dz done pulse", b8.done, 1'b0);
      op8(1'b0, 8'd200, 8'd7, lat);
      chk("u200/7 lat", lat, 10);
      res8("u200/7", 8'd28, 8'd4, 1'b0, 1'b0);
      @(posedge clk);
      #1 chk("u200/7 done pulse", b8.done, 1'b0);
      op8(1'b1, 8'hF9, 8'h02, lat);
      res8("s-7/2", 8'hFD, 8'hFF, 1'b0, 1'b0);
      op8(1'b1, 8'h07, 8'hFE, lat);
      res8("s7/-2", 8'hFD, 8'h01, 1'b0, 1'b0);
      op8(1'b1, 8'h80, 8'hFF, lat);
      res8("s-128/-1", 8'h80, 8'h00, 1'b0, 1'b1);
      op8(1'b0, 8'h80, 8'hFF, lat);
      res8("u128/255", 8'h00, 8'd128, 1'b0, 1'b0);
      // start pulsed mid-operation must be ignored
      @(posedge clk);
      #1;
      b8.signed_mode = 1'b0; b8.dividend = 8'd100; b8.divisor = 8'd3; b8.start = 1'b1;
      @(posedge clk);
      #1 b8.start = 1'b0;
      chk("busy after start", b8.busy, 1'b1);
      repeat (3) @(posedge clk);
      #1 b8.dividend = 8'd50; b8.divisor = 8'd5; b8.start = 1'b1;
      @(posedge clk);
      #1 b8.start = 1'b0;
      n_done = 0;
      repeat (20) begin
         @(posedge clk);
         #1 if (b8.done) n_done++;
      end
      chk("ignore start dones", n_done, 1);
      res8("ignore start", 8'd33, 8'd1, 1'b0, 1'b0);
      // back-to-back: second start issued in the done cycle of the first
      op8(1'b0, 8'd200, 8'd7, lat);
      chk("b2b first q", b8.quotient, 28);
      op8(1'b0, 8'd100, 8'd10, lat);
      chk("b2b lat", lat, 10);
      res8("b2b", 8'd10, 8'd0, 1'b0, 1'b0);
      // reset asserted during iteration 4
      @(posedge clk);
      #1 b8.dividend = 8'd99; b8.divisor = 8'd4; b8.start = 1'b1;
      @(posedge clk);
      #1 b8.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort q", b8.quotient, 0);
      chk("abort r", b8.remainder, 0);
      chk("abort flags", {b8.busy, b8.done, b8.div_by_zero, b8.overflow}, 0);
      @(negedge clk) rst_n = 1'b1;
      n_done = 0;
      repeat (15) begin
         @(posedge clk);
         #1 if (b8.done) n_done++;
      end
      chk("abort no done", n_done, 0);
      op16(16'd65535, 16'd255, lat);
      chk("w16 a q", b16.quotient, 257);
      chk("w16 a r", b16.remainder, 0);
      op16(16'd1000, 16'd1001, lat);
      chk("w16 b lat", lat, 18);
      chk("w16 b q", b16.quotient, 0);
      chk("w16 b r", b16.remainder, 1000);
      chk("w16 b flags", {b16.busy, b16.div_by_zero, b16.overflow}, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
